// File: rtl/vdma_axi4s_to_axi4_burst_core.sv
// Video write DMA: stores a tuser-delimited AXI4-Stream frame line by line into memory
// through an AXI4 write master with shortened tail bursts and a bounded number of open bursts.
module vdma_axi4s_to_axi4_burst_core #(
    parameter int AXI4_ID_WIDTH   = 6,
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_LEN_WIDTH  = 8,
    parameter int AXI4_DATA_SIZE  = 2,
    parameter int AXI4_DATA_WIDTH = (8 << AXI4_DATA_SIZE),
    parameter int MAX_OUTSTANDING = 8,
    parameter int STRIDE_WIDTH    = 14,
    parameter int INDEX_WIDTH     = 8,
    parameter int H_WIDTH         = 12,
    parameter int V_WIDTH         = 12
) (
    input  logic                         aclk,
    input  logic                         aresetn,

    input  logic                         ctl_enable,
    input  logic                         ctl_update,
    output logic                         ctl_busy,
    output logic [INDEX_WIDTH-1:0]       ctl_index,
    output logic                         status_bresp_err,
    output logic                         status_tlast_err,
    input  logic                         status_clear,

    input  logic [AXI4_ADDR_WIDTH-1:0]   param_addr,
    input  logic [STRIDE_WIDTH-1:0]      param_stride,
    input  logic [H_WIDTH-1:0]           param_width,
    input  logic [V_WIDTH-1:0]           param_height,
    input  logic [AXI4_LEN_WIDTH-1:0]    param_awlen,

    output logic [AXI4_ID_WIDTH-1:0]     m_axi4_awid,
    output logic [AXI4_ADDR_WIDTH-1:0]   m_axi4_awaddr,
    output logic [1:0]                   m_axi4_awburst,
    output logic [3:0]                   m_axi4_awcache,
    output logic [AXI4_LEN_WIDTH-1:0]    m_axi4_awlen,
    output logic                         m_axi4_awlock,
    output logic [2:0]                   m_axi4_awprot,
    output logic [3:0]                   m_axi4_awqos,
    output logic [3:0]                   m_axi4_awregion,
    output logic [2:0]                   m_axi4_awsize,
    output logic                         m_axi4_awvalid,
    input  logic                         m_axi4_awready,

    output logic [AXI4_DATA_WIDTH-1:0]   m_axi4_wdata,
    output logic [AXI4_DATA_WIDTH/8-1:0] m_axi4_wstrb,
    output logic                         m_axi4_wlast,
    output logic                         m_axi4_wvalid,
    input  logic                         m_axi4_wready,

    input  logic [AXI4_ID_WIDTH-1:0]     m_axi4_bid,
    input  logic [1:0]                   m_axi4_bresp,
    input  logic                         m_axi4_bvalid,
    output logic                         m_axi4_bready,

    input  logic                         s_axi4s_tuser,
    input  logic                         s_axi4s_tlast,
    input  logic [AXI4_DATA_WIDTH-1:0]   s_axi4s_tdata,
    input  logic                         s_axi4s_tvalid,
    output logic                         s_axi4s_tready
);

    localparam int AW    = AXI4_ADDR_WIDTH;
    localparam int LW    = AXI4_LEN_WIDTH;
    localparam int CW    = (LW + 1 > H_WIDTH) ? LW + 1 : H_WIDTH;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Beats in the next burst: full awlen+1 unless the line remainder is shorter.
    function automatic logic [CW-1:0] burst_beats(input logic [LW-1:0] len,
                                                  input logic [H_WIDTH-1:0] rem);
        logic [CW-1:0] a;
        logic [CW-1:0] r;
        a = CW'(len) + CW'(1);
        r = CW'(rem);
        return (a < r) ? a : r;
    endfunction

    logic [1:0]              state;
    logic                    frame_zero;

    logic [AW-1:0]           sh_addr;
    logic [STRIDE_WIDTH-1:0] sh_stride;
    logic [H_WIDTH-1:0]      sh_width;
    logic [V_WIDTH-1:0]      sh_height;
    logic [LW-1:0]           sh_awlen;

    logic [AW-1:0]           p_addr;
    logic [H_WIDTH-1:0]      p_width;
    logic [V_WIDTH-1:0]      p_height;

    logic [CNT_W-1:0]        ob_cnt;
    logic [CNT_W-1:0]        ob_cnt_nxt;

    logic [AW-1:0]           aw_cur;
    logic [AW-1:0]           aw_base;
    logic [H_WIDTH-1:0]      aw_rem;
    logic [V_WIDTH-1:0]      aw_lines;
    logic                    aw_done;
    logic [AW-1:0]           awaddr_r;
    logic [LW-1:0]           awlen_r;
    logic                    awvalid_r;
    logic [CW-1:0]           aw_beats;
    logic                    aw_line_end;
    logic                    aw_hs;
    logic                    aw_load;

    logic [H_WIDTH-1:0]      w_rem;
    logic [V_WIDTH-1:0]      w_lines;
    logic [CW-1:0]           w_bcnt;
    logic                    w_done;
    logic [AXI4_DATA_WIDTH-1:0] wdata_r;
    logic                    wlast_r;
    logic                    wvalid_r;
    logic [CW-1:0]           w_bl;
    logic                    w_line_end;
    logic                    w_load;

    logic                    arm;
    logic                    start;
    logic                    t_hs;
    logic                    b_dec;
    logic                    b_err;
    logic                    t_err;
    logic                    frame_done;
    logic                    unused_bid;

    assign unused_bid = ^m_axi4_bid;

    // Values being armed: the live params when an update is requested, else the shadow copy.
    assign p_addr   = ctl_update ? param_addr   : sh_addr;
    assign p_width  = ctl_update ? param_width  : sh_width;
    assign p_height = ctl_update ? param_height : sh_height;

    assign arm   = ctl_enable && ((state == ST_IDLE) ||
                                  (state == ST_DRAIN && ob_cnt == '0));
    assign t_hs  = s_axi4s_tvalid && s_axi4s_tready;
    assign start = (state == ST_SKIP) && !frame_zero && t_hs && s_axi4s_tuser;

    assign s_axi4s_tready = (state == ST_SKIP) ||
                            ((state == ST_RUN) && !w_done && (!wvalid_r || m_axi4_wready));

    assign ctl_busy   = (state != ST_IDLE);
    assign frame_done = aw_done && !awvalid_r && w_done && !wvalid_r;

    // ---------------- outstanding burst accounting
    assign aw_hs = awvalid_r && m_axi4_awready;
    assign b_dec = m_axi4_bvalid && (ob_cnt != '0);

    always_comb begin
        ob_cnt_nxt = ob_cnt;
        if (aw_hs && !b_dec)
            ob_cnt_nxt = ob_cnt + CNT_W'(1);
        else if (!aw_hs && b_dec)
            ob_cnt_nxt = ob_cnt - CNT_W'(1);
    end

    // ---------------- FSM, shadow params, index
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            ctl_index  <= '0;
            frame_zero <= 1'b0;
            ob_cnt     <= '0;
            sh_addr    <= '0;
            sh_stride  <= '0;
            sh_width   <= '0;
            sh_height  <= '0;
            sh_awlen   <= '0;
        end else begin
            ob_cnt <= ob_cnt_nxt;
            case (state)
                ST_IDLE:  if (ctl_enable) state <= ST_SKIP;
                ST_SKIP:  if (frame_zero) state <= ST_DRAIN;
                          else if (start) state <= ST_RUN;
                ST_RUN:   if (frame_done) state <= ST_DRAIN;
                default:  if (ob_cnt == '0) state <= ctl_enable ? ST_SKIP : ST_IDLE;
            endcase
            if (arm) begin
                ctl_index  <= ctl_index + INDEX_WIDTH'(1);
                frame_zero <= (p_width == '0) || (p_height == '0);
                if (ctl_update) begin
                    sh_addr   <= param_addr;
                    sh_stride <= param_stride;
                    sh_width  <= param_width;
                    sh_height <= param_height;
                    sh_awlen  <= param_awlen;
                end
            end
        end
    end

    // ---------------- AW channel
    assign aw_beats    = burst_beats(sh_awlen, aw_rem);
    assign aw_line_end = (CW'(aw_rem) == aw_beats);
    assign aw_load     = (state == ST_RUN) && !aw_done && (!awvalid_r || m_axi4_awready) &&
                         (ob_cnt_nxt < CNT_W'(MAX_OUTSTANDING));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_cur    <= '0;
            aw_base   <= '0;
            aw_rem    <= '0;
            aw_lines  <= '0;
            aw_done   <= 1'b0;
            awaddr_r  <= '0;
            awlen_r   <= '0;
            awvalid_r <= 1'b0;
        end else begin
            if (aw_load)
                awvalid_r <= 1'b1;
            else if (m_axi4_awready)
                awvalid_r <= 1'b0;

            if (arm) begin
                aw_cur   <= p_addr;
                aw_base  <= p_addr;
                aw_rem   <= p_width;
                aw_lines <= p_height;
                aw_done  <= 1'b0;
            end else if (aw_load) begin
                awaddr_r <= aw_cur;
                awlen_r  <= LW'(aw_beats - CW'(1));
                if (aw_line_end) begin
                    aw_rem   <= sh_width;
                    aw_base  <= aw_base + AW'(sh_stride);
                    aw_cur   <= aw_base + AW'(sh_stride);
                    aw_lines <= aw_lines - V_WIDTH'(1);
                    if (aw_lines == V_WIDTH'(1))
                        aw_done <= 1'b1;
                end else begin
                    aw_cur <= aw_cur + (AW'(aw_beats) << AXI4_DATA_SIZE);
                    aw_rem <= aw_rem - H_WIDTH'(aw_beats);
                end
            end
        end
    end

    // ---------------- W channel: burst framing tracked separately from AW so W can lead
    assign w_load     = start || ((state == ST_RUN) && !w_done && t_hs);
    assign w_bl       = (w_bcnt == '0) ? burst_beats(sh_awlen, w_rem) : w_bcnt;
    assign w_line_end = (w_rem == H_WIDTH'(1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_rem    <= '0;
            w_lines  <= '0;
            w_bcnt   <= '0;
            w_done   <= 1'b0;
            wdata_r  <= '0;
            wlast_r  <= 1'b0;
            wvalid_r <= 1'b0;
        end else begin
            if (w_load)
                wvalid_r <= 1'b1;
            else if (m_axi4_wready)
                wvalid_r <= 1'b0;

            if (arm) begin
                w_rem   <= p_width;
                w_lines <= p_height;
                w_bcnt  <= '0;
                w_done  <= 1'b0;
            end else if (w_load) begin
                wdata_r <= s_axi4s_tdata;
                wlast_r <= (w_bl == CW'(1));
                w_bcnt  <= w_bl - CW'(1);
                if (w_line_end) begin
                    w_rem   <= sh_width;
                    w_lines <= w_lines - V_WIDTH'(1);
                    if (w_lines == V_WIDTH'(1))
                        w_done <= 1'b1;
                end else begin
                    w_rem <= w_rem - H_WIDTH'(1);
                end
            end
        end
    end

    // ---------------- sticky status; line count is never resynchronised to tlast
    assign b_err = m_axi4_bvalid && (m_axi4_bresp != 2'b00);
    assign t_err = w_load && ((s_axi4s_tlast != w_line_end) ||
                              ((state == ST_RUN) && s_axi4s_tuser));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            status_bresp_err <= 1'b0;
            status_tlast_err <= 1'b0;
        end else if (status_clear) begin
            status_bresp_err <= 1'b0;
            status_tlast_err <= 1'b0;
        end else begin
            if (b_err) status_bresp_err <= 1'b1;
            if (t_err) status_tlast_err <= 1'b1;
        end
    end

    // ---------------- outputs
    assign m_axi4_awid     = '0;
    assign m_axi4_awaddr   = awaddr_r;
    assign m_axi4_awburst  = 2'b01;
    assign m_axi4_awcache  = 4'b0001;
    assign m_axi4_awlen    = awlen_r;
    assign m_axi4_awlock   = 1'b0;
    assign m_axi4_awprot   = 3'b000;
    assign m_axi4_awqos    = 4'd0;
    assign m_axi4_awregion = 4'd0;
    assign m_axi4_awsize   = 3'(AXI4_DATA_SIZE);
    assign m_axi4_awvalid  = awvalid_r;
    assign m_axi4_wdata    = wdata_r;
    assign m_axi4_wstrb    = '1;
    assign m_axi4_wlast    = wlast_r;
    assign m_axi4_wvalid   = wvalid_r;
    assign m_axi4_bready   = 1'b1;

endmodule
